ror_wb_5bit: RTL and testbench

Writeback stage directly downstream of the 5-bit rotate-right unit. It accepts the rotator's combinational result (z, cf, sf, zf) through a valid/ready handshake and buffers it in a 2-entry FIFO. It presents the results in order to the register-file write port. On every retire it updates the architectural flag register, counts retired operations, and flags inconsistent sf/zf values from the rotator with a sticky error bit.

---
 rtl/ror_wb_5bit.sv | 133 +++++++++++++
 tb/tb_ror_wb_5bit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ror_wb_5bit.sv
// Writeback stage for the 5-bit rotate-right unit.
// Buffers rotator results in a 2-entry FIFO and presents them in order to the
// register-file write port. Each retire updates the architectural flags and
// the retired-op counter. A sticky err bit records pushes whose sf/zf do not
// agree with the result data.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// exactly when valid && ready are both high in the preceding cycle. The
// producer holds its payload stable while valid=1 and ready=0. in_ready
// depends only on the registered occupancy, so it has no combinational path
// from out_ready.
module ror_wb_5bit #(
  parameter int DW    = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_z,
  input  logic             in_cf,
  input  logic             in_sf,
  input  logic             in_zf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_z,
  output logic             out_cf,
  output logic             out_sf,
  output logic             out_zf,
  output logic [2:0]       flags,
  output logic [CNT_W-1:0] retired,
  output logic             err,
  input  logic             clr_err
);

  // Each entry holds {z, cf, sf, zf}, stored exactly as received.
  localparam int EW = DW + 3;

  logic [EW-1:0]    mem_q [2];
  logic [EW-1:0]    mem_d [2];
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [2:0]       flags_q, flags_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             err_q, err_d;

  logic             push;
  logic             pop;
  logic             mismatch;
  logic [EW-1:0]    head;

  // Status and head outputs come straight from registers.
  always_comb begin
    in_ready  = (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    head      = mem_q[rd_ptr_q];
    out_z     = head[EW-1:3];
    out_cf    = head[2];
    out_sf    = head[1];
    out_zf    = head[0];
    flags     = flags_q;
    retired   = retired_q;
    err       = err_q;
  end

  // Next-state logic: FIFO bookkeeping, flag retire, counter and error check.
  always_comb begin
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    // sf must equal the result MSB and zf must flag an all-zero result;
    // cf depends on the rotate amount, which this stage cannot see.
    mismatch = (in_zf != (in_z == '0)) || (in_sf != in_z[DW-1]);

    mem_d     = mem_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    flags_d   = flags_q;
    retired_d = retired_q;
    err_d     = err_q;

    if (push) begin
      mem_d[wr_ptr_q] = {in_z, in_cf, in_sf, in_zf};
      wr_ptr_d        = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d  = ~rd_ptr_q;
      flags_d   = {out_cf, out_sf, out_zf};
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // A mismatching push outranks a same-cycle clear.
    if (push && mismatch) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  // State registers; reset discards any buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      count_q   <= 2'd0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      flags_q   <= 3'b000;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= mem_d[i];
      end
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ror_wb_5bit.sv
// Directed bench for ror_wb_5bit: reset, single op, backpressure, streaming,
// error set/clear priority, reset with buffered entries, counter wrap.
module tb_ror_wb_5bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_z;
  logic       in_cf;
  logic       in_sf;
  logic       in_zf;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_z;
  logic       out_cf;
  logic       out_sf;
  logic       out_zf;
  logic [2:0] flags;
  logic [7:0] retired;
  logic       err;
  logic       clr_err;

  int tests_run;
  int tests_failed;

  logic [4:0] zv [5];
  logic [2:0] fv [5];

  ror_wb_5bit #(.DW(5), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_z      (in_z),
    .in_cf     (in_cf),
    .in_sf     (in_sf),
    .in_zf     (in_zf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_cf    (out_cf),
    .out_sf    (out_sf),
    .out_zf    (out_zf),
    .flags     (flags),
    .retired   (retired),
    .err       (err),
    .clr_err   (clr_err)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [4:0] z, input logic [2:0] f);
    in_valid = v;
    in_z     = z;
    {in_cf, in_sf, in_zf} = f;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    drive_in(1'b0, 5'b0, 3'b0);
    zv[0] = 5'b11100; fv[0] = 3'b010;
    zv[1] = 5'b01110; fv[1] = 3'b100;
    zv[2] = 5'b00111; fv[2] = 3'b100;
    zv[3] = 5'b10011; fv[3] = 3'b110;
    zv[4] = 5'b11001; fv[4] = 3'b110;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_flags",     flags,     0);
    chk("rst_retired",   retired,   0);
    chk("rst_err",       err,       0);
    rst_n = 1'b1;
    step();

    // Single op
    drive_in(1'b1, 5'b00111, 3'b100);
    step();
    drive_in(1'b0, 5'b0, 3'b0);
    chk("single_out_valid", out_valid, 1);
    chk("single_out_z",     out_z,     5'b00111);
    chk("single_out_cf",    out_cf,    1);
    chk("single_in_ready",  in_ready,  1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_flags",     flags,     3'b100);
    chk("single_retired",   retired,   1);
    chk("single_out_valid0", out_valid, 0);

    // Full / backpressure
    drive_in(1'b1, 5'b11100, 3'b010);
    step();
    drive_in(1'b1, 5'b01110, 3'b100);
    step();
    chk("full_in_ready", in_ready, 0);
    drive_in(1'b1, 5'b00001, 3'b000);
    step();
    drive_in(1'b0, 5'b0, 3'b0);
    chk("full_hold_z",   out_z,    5'b11100);
    chk("full_in_ready2", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("full_pop1_flags", flags,   3'b010);
    chk("full_pop1_z",     out_z,   5'b01110);
    chk("full_pop1_ret",   retired, 2);
    chk("full_pop1_rdy",   in_ready, 1);
    step();
    chk("full_pop2_flags", flags,   3'b100);
    chk("full_pop2_ret",   retired, 3);
    chk("full_pop2_empty", out_valid, 0);

    // Streaming with simultaneous push/pop at count=1
    for (int i = 0; i < 5; i++) begin
      drive_in(1'b1, zv[i], fv[i]);
      step();
      chk($sformatf("stream_valid_%0d", i), out_valid, 1);
      chk($sformatf("stream_z_%0d", i),     out_z,     zv[i]);
      chk($sformatf("stream_rdy_%0d", i),   in_ready,  1);
      chk($sformatf("stream_ret_%0d", i),   retired,   3 + i);
    end
    drive_in(1'b0, 5'b0, 3'b0);
    step();
    chk("stream_retired", retired,   8);
    chk("stream_flags",   flags,     3'b110);
    chk("stream_empty",   out_valid, 0);
    chk("stream_err",     err,       0);

    // Error detection, sticky, clear, set-wins
    out_ready = 1'b0;
    drive_in(1'b1, 5'b00000, 3'b000);
    step();
    chk("err_set", err, 1);
    out_ready = 1'b1;
    drive_in(1'b1, 5'b00101, 3'b100);
    step();
    drive_in(1'b0, 5'b0, 3'b0);
    chk("err_sticky", err, 1);
    step();
    out_ready = 1'b0;
    chk("err_flags",   flags,   3'b100);
    chk("err_retired", retired, 10);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("err_clear", err, 0);
    clr_err = 1'b1;
    drive_in(1'b1, 5'b10000, 3'b000);
    step();
    clr_err = 1'b0;
    chk("err_set_wins", err, 1);

    // Reset with two entries buffered
    drive_in(1'b1, 5'b00001, 3'b000);
    step();
    drive_in(1'b0, 5'b0, 3'b0);
    chk("prerst_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready",  in_ready,  1);
    chk("midrst_flags",     flags,     0);
    chk("midrst_retired",   retired,   0);
    chk("midrst_err",       err,       0);
    #3;
    rst_n = 1'b1;
    step();
    chk("postrst_empty", out_valid, 0);

    // Counter wrap: 257 retires
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      drive_in(1'b1, 5'b00001, 3'b000);
      step();
    end
    chk("wrap_256", retired, 0);
    drive_in(1'b0, 5'b0, 3'b0);
    step();
    chk("wrap_257", retired, 1);
    chk("wrap_err", err,     0);
    chk("wrap_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
